// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
// Frame states and the fixed character width.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;
endpackage

// File: rtl/uart_kbd_rx_if.sv
// Keyboard-side bundle between the UART receiver and the CPU.
// master = receiver, slave = CPU glue.
interface uart_kbd_rx_if;
  logic       pop;
  logic [7:0] keyboard;
  logic       en_inp;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  pop,
    output keyboard,
    output en_inp,
    output frame_err,
    output overrun
  );

  modport slave (
    output pop,
    input  keyboard,
    input  en_inp,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head is visible without a pop.
// A push into a full FIFO only lands when a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_kbd_rx.sv
// 8N1 UART receiver feeding the CPU keyboard port via a FIFO.
// A low stop bit parks the FSM in BREAK until the line idles.
module uart_kbd_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_kbd_rx_if.master kbd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  =
    IW'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      rx_q1;
  logic                      rx_s;
  logic                      frame_err;
  logic                      overrun;
  logic                      push;
  logic                      empty;
  logic                      full;
  logic [UART_DATA_BITS-1:0] head;
  logic [$clog2(FIFO_DEPTH):0] fcount;

  // shift is complete by the stop sample, so push straight from it
  assign push = (state == STOP) &&
                (cnt == BIT_LAST) && rx_s;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (kbd.pop),
    .din   (shift),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .count (fcount)
  );

  assign kbd.keyboard  = empty ? '0 : head;
  assign kbd.en_inp    = (fcount != '0);
  assign kbd.frame_err = frame_err;
  assign kbd.overrun   = overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_q1     <= 1'b1;
      rx_s      <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_q1     <= rx;
      rx_s      <= rx_q1;
      frame_err <= 1'b0;
      overrun   <= push && full && !kbd.pop;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_s;
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_kbd_rx.md
Name: uart_kbd_rx

Overview:
- Serial keyboard front end for the 16-bit accumulator CPU.
- Deserialises 8N1 UART frames from an external terminal and buffers the bytes in a small FIFO.
- Presents the head byte on the CPU's 8-bit keyboard input.
- Drives the CPU's en_inp input-flag level while data is waiting.
- Top-level glue pulses pop when the CPU completes an INP instruction.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (≥4; 434 = 50 MHz / 115200).
- FIFO_DEPTH, 4, receive FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- pop  input  1  one-cycle strobe: consume the FIFO head.
- keyboard  output  8  FIFO head byte; 8'h00 when empty.
- en_inp  output  1  high while FIFO is non-empty.
- frame_err  output  1  one-cycle pulse when a bad stop bit is seen.
- overrun  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, rst sampled high at a clk edge):
  - FSM goes to IDLE; baud counter and bit counter are zeroed.
  - FIFO is emptied.
  - keyboard=8'h00, en_inp=0, frame_err=0, overrun=0.
  - Synchroniser flops are set to 1.
  - Reset mid-frame abandons the partial byte.
- Input synchroniser:
  - rx passes through 2 flops to give rx_s; all logic uses rx_s only.
- FSM states:
  - IDLE: on rx_s==0, go to START and clear the baud counter.
  - START: count CLKS_PER_BIT/2 cycles (integer divide), then sample rx_s.
    - rx_s==0: go to DATA, bit index=0, clear counter.
    - rx_s==1: glitch; return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit index], LSB first.
    - After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s==1: push the byte and go to IDLE.
    - rx_s==0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE.
    - A held-low line never produces repeated frames or repeated frame_err pulses.
- Baud counter width: clog2(CLKS_PER_BIT). It wraps to 0 on each sample.
- FIFO:
  - Show-ahead: keyboard = mem[rd_ptr] combinationally when count≠0, else 8'h00.
  - en_inp = (count≠0), derived from registered count.
  - Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
  - count is clog2(FIFO_DEPTH)+1 bits.
  - Push latency: push occurs at the clk edge of the stop-bit sample; en_inp and keyboard are valid the following cycle.
  - pop when empty: ignored, no flag.
  - push when full, no pop: byte dropped, overrun pulses 1 cycle, FIFO unchanged.
  - push and pop in the same cycle when full: both occur, count unchanged, no overrun.
  - push and pop in the same cycle when empty: pop ignored, push occurs, count becomes 1.
  - push and pop in the same cycle otherwise: both occur, count unchanged.
  - pop while a frame is in progress is independent of the FSM.
- frame_err and overrun never assert in the same cycle as reset. Both are registered.
- rst has priority over all other events.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - UART_DATA_BITS=8 constant.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH=FIFO_DEPTH):
  - Ports: push, pop, din, dout, empty, full, count; synchronous active-high reset.
  - Reusable later for a display TX path.
- The FSM, synchroniser and baud counter live in uart_kbd_rx.

Test Plan:
- Bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4.
- Single byte: send 0x41 → en_inp rises within 2+16/2+16*9+2 cycles, keyboard=0x41. Pulse pop → next cycle en_inp=0, keyboard=0x00.
- Start glitch: drive rx low 4 cycles, then high → FSM back in IDLE, no push, no flags; a following 0x7E is received correctly.
- Framing error: send 0x55 with stop bit 0 and hold rx low 200 cycles → exactly one frame_err pulse, en_inp stays 0. Release rx and send 0x12 → keyboard=0x12.
- Overrun: send 0x01..0x05 with no pop → single overrun pulse at the 5th stop sample. Four pops yield 0x01, 0x02, 0x03, 0x04, then en_inp=0.
- Full plus simultaneous pop: fill with 0x10..0x13, send 0x14 and pulse pop on its push cycle → no overrun. Pops yield 0x11, 0x12, 0x13, 0x14.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 3 of 0xFF → en_inp=0, no push. Next frame 0xA5 → keyboard=0xA5.
